// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file and its read ports.
`include "utils.v"

package reg_file_pkg;

    typedef logic [`ROB_RANGE] rob_tag_t;
    typedef logic [`REG_RANGE] reg_idx_t;

    // x0 is hardwired, so only nonzero indices name real state.
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return idx != '0;
    endfunction

    function automatic logic tag_match(input rob_tag_t tag, input rob_tag_t rob_alias);
        return tag == rob_alias;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational source-operand read: x0 masking plus the commit bypass
// mux, compiled in only when REG_FILE_BYPASS_EN is defined.
`include "utils.v"

module reg_file_read_port
    import reg_file_pkg::*;
(
    input  logic [`REG_RANGE]  rs,
    input  logic [`ROB_RANGE]  tag_rs,
    input  logic [`DATA_RANGE] value_rs,
`ifdef REG_FILE_BYPASS_EN
    input  logic               commit_valid,
    input  logic [`REG_RANGE]  commit_reg,
    input  logic [`ROB_RANGE]  commit_alias,
    input  logic [`DATA_RANGE] commit_result,
`endif
    output logic [`ROB_RANGE]  q,
    output logic [`DATA_RANGE] v
);

    always_comb begin
        q = '0;
        v = '0;
        if (is_arch_reg(rs)) begin
            q = tag_rs;
            v = value_rs;
`ifdef REG_FILE_BYPASS_EN
            // Forward a commit that is about to clear this register's tag.
            if (commit_valid && (commit_reg == rs) && tag_match(tag_rs, commit_alias)) begin
                q = '0;
                v = commit_result;
            end
`endif
        end
    end

endmodule

// File: rtl/utils.v
// Shared width header for the out-of-order core: register index, ROB tag and data widths.
`ifndef UTILS_V
`define UTILS_V
`define REG_RANGE  4:0
`define ROB_SIZE   16
`define ROB_RANGE  3:0
`define DATA_RANGE 31:0
`endif

// File: rtl/reg_file.sv
// Architectural register file with rename tags for dispatch, commit writes from
// the ROB and flush on rollback. Optional same-cycle commit bypass: REG_FILE_BYPASS_EN.
`include "utils.v"

module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_COUNT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    input  logic               valid_from_rob,
    input  logic [`REG_RANGE]  reg_id_from_rob,
    input  logic [`ROB_RANGE]  alias_from_rob,
    input  logic [`DATA_RANGE] result_from_rob,
    input  logic               valid_from_disp,
    input  logic [`REG_RANGE]  rd_from_disp,
    input  logic [`ROB_RANGE]  alias_from_disp,
    input  logic [`REG_RANGE]  rs1_from_disp,
    input  logic [`REG_RANGE]  rs2_from_disp,
    output logic [`ROB_RANGE]  Qi_to_disp,
    output logic [`ROB_RANGE]  Qj_to_disp,
    output logic [`DATA_RANGE] Vi_to_disp,
    output logic [`DATA_RANGE] Vj_to_disp
);

    logic [`DATA_RANGE] value_q [REG_COUNT];
    logic [`ROB_RANGE]  tag_q   [REG_COUNT];

    logic commit_en;
    logic rename_en;

    assign commit_en = valid_from_rob && is_arch_reg(reg_id_from_rob);
    assign rename_en = valid_from_disp && is_arch_reg(rd_from_disp) && !rollback;

    // Rename is written last so it overrides a same-cycle tag clear from commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                for (int unsigned i = 0; i < REG_COUNT; i++) begin
                    tag_q[i] <= '0;
                end
            end
            if (commit_en) begin
                value_q[reg_id_from_rob] <= result_from_rob;
                if (tag_match(tag_q[reg_id_from_rob], alias_from_rob)) begin
                    tag_q[reg_id_from_rob] <= '0;
                end
            end
            if (rename_en) begin
                tag_q[rd_from_disp] <= alias_from_disp;
            end
        end
    end

    reg_file_read_port u_read_rs1 (
        .rs            (rs1_from_disp),
        .tag_rs        (tag_q[rs1_from_disp]),
        .value_rs      (value_q[rs1_from_disp]),
`ifdef REG_FILE_BYPASS_EN
        .commit_valid  (valid_from_rob),
        .commit_reg    (reg_id_from_rob),
        .commit_alias  (alias_from_rob),
        .commit_result (result_from_rob),
`endif
        .q             (Qi_to_disp),
        .v             (Vi_to_disp)
    );

    reg_file_read_port u_read_rs2 (
        .rs            (rs2_from_disp),
        .tag_rs        (tag_q[rs2_from_disp]),
        .value_rs      (value_q[rs2_from_disp]),
`ifdef REG_FILE_BYPASS_EN
        .commit_valid  (valid_from_rob),
        .commit_reg    (reg_id_from_rob),
        .commit_alias  (alias_from_rob),
        .commit_result (result_from_rob),
`endif
        .q             (Qj_to_disp),
        .v             (Vj_to_disp)
    );

endmodule
